// File: rtl/max7219_pkg.sv
// Shared constants for the MAX7219 frame-buffer controller: register addresses,
// power-up command table and controller state encoding.
package max7219_pkg;

    localparam logic [3:0] REG_NOOP       = 4'h0;
    localparam logic [3:0] REG_DIGIT0     = 4'h1;
    localparam logic [3:0] REG_DECODE     = 4'h9;
    localparam logic [3:0] REG_INTENSITY  = 4'hA;
    localparam logic [3:0] REG_SCAN_LIMIT = 4'hB;
    localparam logic [3:0] REG_SHUTDOWN   = 4'hC;
    localparam logic [3:0] REG_TEST       = 4'hF;

    localparam logic [2:0] INIT_LAST          = 3'd4;
    localparam logic [2:0] INIT_INTENSITY_IDX = 3'd3;

    // Intensity entry carries a zero data field; the controller fills in its parameter.
    localparam logic [15:0] INIT_CMDS [0:4] = '{
        {4'h0, REG_TEST,       8'h00},
        {4'h0, REG_DECODE,     8'h00},
        {4'h0, REG_SCAN_LIMIT, 8'h07},
        {4'h0, REG_INTENSITY,  8'h00},
        {4'h0, REG_SHUTDOWN,   8'h01}
    };

    typedef enum logic [2:0] {
        RESET_WAIT = 3'd0,
        INIT       = 3'd1,
        IDLE       = 3'd2,
        FETCH      = 3'd3,
        SEND       = 3'd4,
        WAIT_HI    = 3'd5,
        WAIT_LO    = 3'd6
    } state_e;

    function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] intensity);
        logic [15:0] w;
        w = '0;
        if (idx <= INIT_LAST) begin
            w = INIT_CMDS[idx];
        end
        if (idx == INIT_INTENSITY_IDX) begin
            w[3:0] = intensity;
        end
        return w;
    endfunction

endpackage

// File: rtl/max7219_fb_ctrl_if.sv
// Bundle of the controller's frame-buffer, refresh and SPI-driver signals.
// master = controller side, slave = frame buffer / driver / host side.
interface max7219_fb_ctrl_if #(
    parameter int SEG_ROWS = 2,
    parameter int SEG_COLS = 2
);
    localparam int N  = SEG_ROWS * SEG_COLS;
    localparam int AW = $clog2(SEG_ROWS * 8);

    logic              i_Refresh;
    logic              o_Fb_Rd_En;
    logic [AW-1:0]     o_Fb_Addr;
    logic [SEG_COLS*8-1:0] i_Fb_Row;
    logic              i_Busy;
    logic              o_Data_Ready;
    logic [16*N-1:0]   o_Data;
    logic              o_Init_Done;
    logic              o_Frame_Done;

    modport master (
        input  i_Refresh, i_Fb_Row, i_Busy,
        output o_Fb_Rd_En, o_Fb_Addr, o_Data_Ready, o_Data, o_Init_Done, o_Frame_Done
    );

    modport slave (
        output i_Refresh, i_Fb_Row, i_Busy,
        input  o_Fb_Rd_En, o_Fb_Addr, o_Data_Ready, o_Data, o_Init_Done, o_Frame_Done
    );

endinterface

// File: rtl/max7219_fb_ctrl.sv
// Streams an 8x8-device frame buffer to a cascade of MAX7219s, one stripe per word.
// Optional macro MAX7219_FB_CTRL_AUTO_REFRESH_EN: start passes back-to-back without i_Refresh.
module max7219_fb_ctrl
    import max7219_pkg::*;
#(
    parameter int         SEG_ROWS  = 2,
    parameter int         SEG_COLS  = 2,
    parameter logic [3:0] INTENSITY = 4'h7
) (
    input  logic                                 i_Clk,
    input  logic                                 i_Rst_n,
    input  logic                                 i_Refresh,
    output logic                                 o_Fb_Rd_En,
    output logic [$clog2(SEG_ROWS*8)-1:0]        o_Fb_Addr,
    input  logic [SEG_COLS*8-1:0]                i_Fb_Row,
    input  logic                                 i_Busy,
    output logic                                 o_Data_Ready,
    output logic [16*SEG_ROWS*SEG_COLS-1:0]      o_Data,
    output logic                                 o_Init_Done,
    output logic                                 o_Frame_Done
);

    localparam int          N      = SEG_ROWS * SEG_COLS;
    localparam int          DW     = 16 * N;
    localparam int          AW     = $clog2(SEG_ROWS * 8);
    localparam int          CW     = $clog2(SEG_ROWS + 1);
    localparam int unsigned N_U    = N;
    localparam int unsigned COLS_U = SEG_COLS;

`ifdef MAX7219_FB_CTRL_AUTO_REFRESH_EN
    localparam logic AUTO_REFRESH = 1'b1;
`else
    localparam logic AUTO_REFRESH = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [2:0]      init_idx_q, init_idx_d;
    logic [2:0]      stripe_q, stripe_d;
    logic [CW-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic [CW-1:0]   rd_row_q, rd_row_d;
    logic [CW-1:0]   cap_row_q, cap_row_d;
    logic            rd_en_q, rd_en_d;
    logic            cap_en_q, cap_en_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            data_ready_q, data_ready_d;
    logic            init_done_q, init_done_d;
    logic            frame_done_q, frame_done_d;
    logic            pend_q, pend_d;

    always_comb begin
        state_d      = state_q;
        init_idx_d   = init_idx_q;
        stripe_d     = stripe_q;
        fetch_cnt_d  = fetch_cnt_q;
        rd_row_d     = rd_row_q;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        cap_en_d     = rd_en_q;
        cap_row_d    = rd_row_q;
        data_d       = data_q;
        data_ready_d = 1'b0;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        pend_d       = pend_q;

        if (i_Refresh && (state_q != IDLE)) begin
            pend_d = 1'b1;
        end

        // Row data arrives one cycle after the read strobe; each row fills SEG_COLS slots directly.
        if (cap_en_q) begin
            for (int unsigned d = 0; d < N_U; d++) begin
                if (d / COLS_U == 32'(cap_row_q)) begin
                    data_d[16*d +: 16] = {4'h0, {1'b0, stripe_q} + 4'd1, i_Fb_Row[8*(d % COLS_U) +: 8]};
                end
            end
        end

        case (state_q)
            RESET_WAIT: begin
                init_idx_d = '0;
                if (!i_Busy) begin
                    state_d = INIT;
                end
            end
            INIT: begin
                for (int unsigned d = 0; d < N_U; d++) begin
                    data_d[16*d +: 16] = init_word(init_idx_q, INTENSITY);
                end
                state_d = SEND;
            end
            IDLE: begin
                if (i_Refresh || pend_q || AUTO_REFRESH) begin
                    pend_d      = 1'b0;
                    stripe_d    = '0;
                    fetch_cnt_d = '0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                if (fetch_cnt_q != CW'(SEG_ROWS)) begin
                    rd_en_d     = 1'b1;
                    addr_d      = AW'({fetch_cnt_q, stripe_q});
                    rd_row_d    = fetch_cnt_q;
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
                if (cap_en_q && (cap_row_q == CW'(SEG_ROWS - 1))) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (!i_Busy) begin
                    data_ready_d = 1'b1;
                    state_d      = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (i_Busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!i_Busy) begin
                    if (!init_done_q) begin
                        if (init_idx_q == INIT_LAST) begin
                            init_done_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            init_idx_d = init_idx_q + 3'd1;
                            state_d    = INIT;
                        end
                    end else if (stripe_q == 3'd7) begin
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        stripe_d    = stripe_q + 3'd1;
                        fetch_cnt_d = '0;
                        state_d     = FETCH;
                    end
                end
            end
            default: begin
                state_d = RESET_WAIT;
            end
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q      <= RESET_WAIT;
            init_idx_q   <= '0;
            stripe_q     <= '0;
            fetch_cnt_q  <= '0;
            rd_row_q     <= '0;
            cap_row_q    <= '0;
            rd_en_q      <= 1'b0;
            cap_en_q     <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            init_idx_q   <= init_idx_d;
            stripe_q     <= stripe_d;
            fetch_cnt_q  <= fetch_cnt_d;
            rd_row_q     <= rd_row_d;
            cap_row_q    <= cap_row_d;
            rd_en_q      <= rd_en_d;
            cap_en_q     <= cap_en_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            data_ready_q <= data_ready_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            pend_q       <= pend_d;
        end
    end

    assign o_Fb_Rd_En   = rd_en_q;
    assign o_Fb_Addr    = addr_q;
    assign o_Data       = data_q;
    assign o_Data_Ready = data_ready_q;
    assign o_Init_Done  = init_done_q;
    assign o_Frame_Done = frame_done_q;

endmodule

// File: doc/max7219_fb_ctrl.md
MAX7219_FB_CTRL -- requirements
Module: max7219_fb_ctrl

Interface
REQ-001 SHALL have parameter SEG_ROWS, default 2, meaning the number of display rows of 8x8 devices in the cascade.
REQ-002 SHALL have parameter SEG_COLS, default 2, meaning the number of display columns of 8x8 devices.
REQ-003 SHALL have parameter INTENSITY, default 4'h7, meaning the MAX7219 intensity register value.
REQ-004 SHALL have ports (N=SEG_ROWS*SEG_COLS):
- i_Clk  in  1  the single clock.
- i_Rst_n  in  1  reset; asynchronous, active-low.
- i_Refresh  in  1  pulse requesting one frame pass.
- o_Fb_Rd_En  out  1  frame-buffer read strobe.
- o_Fb_Addr  out  $clog2(SEG_ROWS*8)  pixel row y.
- i_Fb_Row  in  SEG_COLS*8  row y; bit x = pixel (x,y); valid one cycle after o_Fb_Rd_En.
- i_Busy  in  1  SPI driver busy.
- o_Data_Ready  out  1  one-cycle word-issue pulse.
- o_Data  out  16*N  cascade word.
- o_Init_Done  out  1  init sequence complete.
- o_Frame_Done  out  1  one-cycle pulse at end of a pass.

Function
REQ-005 SHALL place device d=r*SEG_COLS+c in o_Data[16*d +: 16] as {4'b0000, addr[3:0], data[7:0]}.
REQ-006 SHALL use states RESET_WAIT, INIT, IDLE, FETCH, SEND, WAIT_HI, WAIT_LO.
REQ-007 SHALL, after reset, go RESET_WAIT -> INIT once i_Busy=0.
REQ-008 SHALL in INIT broadcast five words, each slot identical and in order: 16'h0F00, 16'h0900, 16'h0B07, {12'h0A0, INTENSITY}, 16'h0C01.
REQ-009 SHALL set o_Init_Done=1 after the fifth word completes and keep it until reset.
REQ-010 SHALL in IDLE start a pass on i_Refresh=1 or a pending request.
REQ-011 SHALL process stripes s=0..7 per pass; per stripe, FETCH reads rows y=8*r+s for r=0..SEG_ROWS-1, one read per cycle, capturing i_Fb_Row one cycle after each read.
REQ-012 SHALL build stripe s with addr=s+1 and slot (r,c) data bit p = pixel (8*c+p, 8*r+s).
REQ-013 SHALL in SEND assert o_Data_Ready for exactly one cycle, and only when i_Busy=0.
REQ-014 SHALL hold o_Data stable from SEND until WAIT_LO exits.
REQ-015 SHALL leave WAIT_HI when i_Busy=1 and leave WAIT_LO when i_Busy=0; the driver raises i_Busy within one cycle of o_Data_Ready.
REQ-016 SHALL pulse o_Frame_Done in the cycle stripe 7 leaves WAIT_LO, then return to IDLE.
REQ-017 SHALL latch one pending request when i_Refresh arrives during a pass or during INIT; multiple arrivals collapse to one, which is serviced immediately after.
REQ-018 SHALL ignore i_Refresh when it coincides with o_Frame_Done while a request is already pending.

Reset
REQ-019 SHALL, on i_Rst_n=0, asynchronously clear o_Data_Ready, o_Data, o_Fb_Rd_En, o_Fb_Addr, o_Init_Done, o_Frame_Done and the pending flag, and enter RESET_WAIT.
REQ-020 SHALL, after a reset mid-pass or mid-init, restart the full init sequence.

Configuration
REQ-021 SHALL, with MAX7219_FB_CTRL_AUTO_REFRESH_EN defined, start a new pass automatically on leaving a pass or INIT, without needing i_Refresh.
REQ-022 SHALL, without MAX7219_FB_CTRL_AUTO_REFRESH_EN, refresh only on request.

Structure
REQ-023 SHALL take from package max7219_pkg: the register-address constants, the init-command table, and the state enum typedef.
REQ-024 SHALL be a single module with no sub-module; it is paired externally with spi_max7219 (DATA_WIDTH=16*N).

Verification
REQ-025 SHALL cover: reset release, i_Busy=0 -> five words, first 64'h0F00_0F00_0F00_0F00, last 64'h0C01_0C01_0C01_0C01; o_Init_Done=1.
REQ-026 SHALL cover: pixel (0,0)=1, others 0, i_Refresh -> first pass word 64'h0100_0100_0100_0101.
REQ-027 SHALL cover: pixel (15,15)=1 only -> eighth word 64'h0880_0800_0800_0800.
REQ-028 SHALL cover: i_Busy held high 100 cycles in WAIT_LO -> o_Data unchanged and no o_Data_Ready.
REQ-029 SHALL cover: three i_Refresh pulses mid-pass -> exactly two passes, 16 words, two o_Frame_Done pulses.
REQ-030 SHALL cover: i_Rst_n low during stripe 3 -> outputs zero immediately, and after release the next word is 64'h0F00_0F00_0F00_0F00.
